systolic_mac_array: RTL and testbench

- Parametrised output-stationary systolic array of DIM x DIM int8 MAC PEs. Computes C[i][j] = sum over k of (A[k][i] + offset) * B[k][j].
- Input skew, zero-fill flush and ordered result drain are all internal.
- Sits behind the CFU command decoder, fed from the A/B global-buffer BRAMs.
- Replaces the fixed 4x4 inline array with valid/ready streaming, backpressure-safe drain and accumulate-across-tiles mode.

---
 rtl/systolic_mac_array_if.sv | 34 +++
 rtl/systolic_mac_array.sv | 192 +++++++++++++++++++
 tb/tb_systolic_mac_array.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mac_array_if.sv
// Streaming bus of the systolic MAC array: configuration, operand beats and
// result drain, each with its own valid/ready pair.
interface systolic_mac_array_if #(
  parameter int DIM    = 4,
  parameter int ACC_W  = 32,
  parameter int KLEN_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [KLEN_W-1:0] cfg_k_len;
  logic [8:0]        cfg_offset;
  logic              cfg_accumulate;
  logic              in_valid;
  logic              in_ready;
  logic [8*DIM-1:0]  in_a;
  logic [8*DIM-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output cfg_valid, cfg_k_len, cfg_offset, cfg_accumulate,
    output in_valid, in_a, in_b, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  cfg_valid, cfg_k_len, cfg_offset, cfg_accumulate,
    input  in_valid, in_a, in_b, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/systolic_mac_array.sv
// Output-stationary DIM x DIM int8 systolic MAC array with internal input skew,
// zero-fill flush and a backpressure-safe row-major result drain.
module systolic_mac_array #(
  parameter int DIM    = 4,
  parameter int ACC_W  = 32,
  parameter int KLEN_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  systolic_mac_array_if.slave bus
);
  localparam int SK_N = (DIM * (DIM - 1)) / 2;
  localparam int NRES = DIM * DIM;
  localparam int NW   = $clog2(NRES);
  localparam int FW   = $clog2(2 * DIM);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  state_e state_q, state_d;
  logic cfg_fire, in_fire, advance;

  logic [KLEN_W-1:0] rem_q;
  logic [8:0]        offset_q;
  logic [FW-1:0]     flush_q;
  logic [NW-1:0]     n_q;

  logic [9:0] ska_q   [SK_N];
  logic       ska_v_q [SK_N];
  logic [7:0] skb_q   [SK_N];
  logic       skb_v_q [SK_N];

  logic [9:0] pa_q   [DIM][DIM];
  logic       pa_v_q [DIM][DIM];
  logic [7:0] pb_q   [DIM][DIM];
  logic       pb_v_q [DIM][DIM];

  logic [ACC_W-1:0] acc_q [NRES];

  logic [9:0]       ent_a  [DIM];
  logic [7:0]       ent_b  [DIM];
  logic [9:0]       row_a  [DIM];
  logic             row_av [DIM];
  logic [7:0]       col_b  [DIM];
  logic             col_bv [DIM];
  logic [17:0]      prod18 [DIM][DIM];

  logic             out_valid_q, out_last_q;
  logic [ACC_W-1:0] out_data_q;

  assign cfg_fire = bus.cfg_valid & bus.cfg_ready;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign advance  = in_fire | (state_q == FLUSH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fire) state_d = (bus.cfg_k_len != '0) ? LOAD : DRAIN;
      LOAD:    if (in_fire && rem_q == KLEN_W'(1)) state_d = FLUSH;
      FLUSH:   if (flush_q == FW'(2 * DIM - 2)) state_d = DRAIN;
      DRAIN:   if (out_valid_q && bus.out_ready && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready = (state_q == IDLE);
    bus.in_ready  = (state_q == LOAD);
    bus.busy      = (state_q != IDLE);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  // Offset is folded in at entry so flush zeros never pick it up; lane i taps
  // the end of its own i-deep skew chain.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      ent_a[i] = '0;
      ent_b[i] = '0;
      if (in_fire) begin
        ent_a[i] = {{2{bus.in_a[8*i+7]}}, bus.in_a[8*i +: 8]} + {offset_q[8], offset_q};
        ent_b[i] = bus.in_b[8*i +: 8];
      end
    end
    row_a[0]  = ent_a[0];
    row_av[0] = in_fire;
    col_b[0]  = ent_b[0];
    col_bv[0] = in_fire;
    for (int i = 1; i < DIM; i++) begin
      row_a[i]  = ska_q[i*(i+1)/2 - 1];
      row_av[i] = ska_v_q[i*(i+1)/2 - 1];
      col_b[i]  = skb_q[i*(i+1)/2 - 1];
      col_bv[i] = skb_v_q[i*(i+1)/2 - 1];
    end
  end

  always_comb begin
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        prod18[i][j] = $signed({{8{pa_q[i][j][9]}}, pa_q[i][j]}) *
                       $signed({{10{pb_q[i][j][7]}}, pb_q[i][j]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= '0;
      offset_q    <= '0;
      flush_q     <= '0;
      n_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int s = 0; s < SK_N; s++) begin
        ska_q[s] <= '0; ska_v_q[s] <= 1'b0;
        skb_q[s] <= '0; skb_v_q[s] <= 1'b0;
      end
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          pa_q[i][j] <= '0; pa_v_q[i][j] <= 1'b0;
          pb_q[i][j] <= '0; pb_v_q[i][j] <= 1'b0;
        end
      for (int n = 0; n < NRES; n++) acc_q[n] <= '0;
    end else begin
      if (cfg_fire) begin
        rem_q    <= bus.cfg_k_len;
        offset_q <= bus.cfg_offset;
        flush_q  <= '0;
        n_q      <= '0;
        if (!bus.cfg_accumulate)
          for (int n = 0; n < NRES; n++) acc_q[n] <= '0;
      end
      if (in_fire) rem_q <= rem_q - KLEN_W'(1);
      if (state_q == FLUSH) flush_q <= flush_q + FW'(1);

      // A bubble freezes every stage, so a held operand pair is never counted twice.
      if (advance) begin
        for (int i = 1; i < DIM; i++) begin
          ska_q[i*(i-1)/2]   <= ent_a[i];
          ska_v_q[i*(i-1)/2] <= in_fire;
          skb_q[i*(i-1)/2]   <= ent_b[i];
          skb_v_q[i*(i-1)/2] <= in_fire;
          for (int s = 1; s < i; s++) begin
            ska_q[i*(i-1)/2 + s]   <= ska_q[i*(i-1)/2 + s - 1];
            ska_v_q[i*(i-1)/2 + s] <= ska_v_q[i*(i-1)/2 + s - 1];
            skb_q[i*(i-1)/2 + s]   <= skb_q[i*(i-1)/2 + s - 1];
            skb_v_q[i*(i-1)/2 + s] <= skb_v_q[i*(i-1)/2 + s - 1];
          end
        end
        for (int i = 0; i < DIM; i++) begin
          pa_q[i][0]   <= row_a[i];
          pa_v_q[i][0] <= row_av[i];
          pb_q[0][i]   <= col_b[i];
          pb_v_q[0][i] <= col_bv[i];
          for (int j = 1; j < DIM; j++) begin
            pa_q[i][j]   <= pa_q[i][j-1];
            pa_v_q[i][j] <= pa_v_q[i][j-1];
            pb_q[j][i]   <= pb_q[j-1][i];
            pb_v_q[j][i] <= pb_v_q[j-1][i];
          end
        end
        for (int i = 0; i < DIM; i++)
          for (int j = 0; j < DIM; j++)
            if (pa_v_q[i][j] && pb_v_q[i][j])
              acc_q[i*DIM+j] <= acc_q[i*DIM+j] + {{(ACC_W-18){prod18[i][j][17]}}, prod18[i][j]};
      end

      // First DRAIN cycle only loads the output register; afterwards each fire steps n.
      if (state_q == DRAIN) begin
        if (!out_valid_q) begin
          out_valid_q <= 1'b1;
          out_data_q  <= acc_q[n_q];
          out_last_q  <= (n_q == NW'(NRES - 1));
        end else if (bus.out_ready) begin
          if (out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else begin
            n_q        <= n_q + NW'(1);
            out_data_q <= acc_q[n_q + NW'(1)];
            out_last_q <= ((n_q + NW'(1)) == NW'(NRES - 1));
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed, scoreboard-based bench for the systolic MAC array: a small integer
// model predicts every drained result, which is compared as it leaves the DUT.
module tb_systolic_mac_array;
  localparam int DIM    = 4;
  localparam int ACC_W  = 32;
  localparam int KLEN_W = 16;
  localparam int NRES   = DIM * DIM;

  logic clk = 1'b0;
  logic reset;

  systolic_mac_array_if #(.DIM(DIM), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) bus();

  systolic_mac_array #(.DIM(DIM), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int modelAcc [NRES];
  int expQ [$];
  int waitCycles;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic clearModel();
    for (int n = 0; n < NRES; n++) modelAcc[n] = 0;
  endtask

  task automatic driveCfg(input int kLen, input int off, input bit acc);
    checkVal("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid      = 1'b1;
    bus.cfg_k_len      = kLen[KLEN_W-1:0];
    bus.cfg_offset     = off[8:0];
    bus.cfg_accumulate = acc;
    if (!acc) clearModel();
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // One accepted operand beat; the model accumulates it at the same moment.
  task automatic driveBeat(input int k, input int mode, input int off, input bit bubbles);
    logic signed [7:0] aL [DIM];
    logic signed [7:0] bL [DIM];
    logic signed [8:0] off9;
    off9 = off[8:0];
    for (int i = 0; i < DIM; i++) begin
      case (mode)
        0: begin aL[i] = (i == k) ? 8'sd1 : 8'sd0; bL[i] = 8'(4 * k + i + 1); end
        1: begin aL[i] = -8'sd1; bL[i] = 8'sd3; end
        default: begin aL[i] = -8'sd128; bL[i] = -8'sd128; end
      endcase
    end
    if (bubbles)
      while ($urandom_range(1, 0) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        tick();
      end
    bus.in_valid = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      bus.in_a[8*i +: 8] = aL[i];
      bus.in_b[8*i +: 8] = bL[i];
    end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        modelAcc[i*DIM+j] += (int'(aL[i]) + int'(off9)) * int'(bL[j]);
  endtask

  task automatic applyStimulus(input int kLen, input int off, input bit acc, input int mode, input bit bubbles);
    driveCfg(kLen, off, acc);
    for (int k = 0; k < kLen; k++) driveBeat(k, mode, off, bubbles);
    for (int n = 0; n < NRES; n++) expQ.push_back(modelAcc[n]);
  endtask

  // Drains the whole result set, optionally with out_ready high one cycle in three.
  task automatic checkOutput(input string tag, input bit stall, output int waitCnt);
    int cyc;
    int idx;
    int expVal;
    waitCnt = 0;
    while (!bus.out_valid && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checkVal({tag, "_out_valid_rise"}, bus.out_valid, 1);
    cyc = 0;
    idx = 0;
    while (expQ.size() > 0 && cyc < 500 && bus.out_valid) begin
      bus.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      if (bus.out_ready) begin
        expVal = expQ.pop_front();
        checkVal($sformatf("%s_data[%0d]", tag, idx), bus.out_data, 64'(expVal[ACC_W-1:0]));
        checkVal($sformatf("%s_last[%0d]", tag, idx), bus.out_last, (idx == NRES - 1));
        idx++;
      end else begin
        checkVal($sformatf("%s_hold[%0d]", tag, idx), bus.out_data, 64'(expQ[0]));
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    checkVal({tag, "_results_left"}, expQ.size(), 0);
    checkVal({tag, "_valid_after"}, bus.out_valid, 0);
    checkVal({tag, "_busy_after"}, bus.busy, 0);
    expQ.delete();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    bus.cfg_valid      = 1'b0;
    bus.cfg_k_len      = '0;
    bus.cfg_offset     = '0;
    bus.cfg_accumulate = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_a           = '0;
    bus.in_b           = '0;
    bus.out_ready      = 1'b0;
    clearModel();

    tick();
    checkVal("rst_cfg_ready", bus.cfg_ready, 1);
    checkVal("rst_in_ready", bus.in_ready, 0);
    checkVal("rst_busy", bus.busy, 0);
    checkVal("rst_out_valid", bus.out_valid, 0);
    checkVal("rst_out_data", bus.out_data, 0);
    checkVal("rst_out_last", bus.out_last, 0);
    reset = 1'b0;
    tick();

    $display("[TB] identity run, offset 0");
    applyStimulus(4, 0, 1'b0, 0, 1'b0);
    checkVal("id_flush_in_ready", bus.in_ready, 0);
    checkVal("id_flush_busy", bus.busy, 1);
    checkOutput("id", 1'b0, waitCycles);
    checkVal("id_latency", waitCycles, 8);

    $display("[TB] offset 128, all -1 x 3, k_len 8");
    applyStimulus(8, 128, 1'b0, 1, 1'b0);
    checkOutput("off", 1'b0, waitCycles);

    $display("[TB] identity run with bubbles and output stalls");
    applyStimulus(4, 0, 1'b0, 0, 1'b1);
    checkOutput("stall", 1'b1, waitCycles);

    $display("[TB] accumulate across tiles");
    applyStimulus(4, 0, 1'b1, 0, 1'b0);
    checkOutput("acc1", 1'b0, waitCycles);
    applyStimulus(4, 0, 1'b0, 0, 1'b0);
    checkOutput("acc0", 1'b0, waitCycles);

    $display("[TB] reset in the middle of LOAD");
    driveCfg(4, 0, 1'b0);
    driveBeat(0, 0, 0, 1'b0);
    driveBeat(1, 0, 0, 1'b0);
    checkVal("mid_in_ready_load", bus.in_ready, 1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("mid_rst_cfg_ready", bus.cfg_ready, 1);
    checkVal("mid_rst_in_ready", bus.in_ready, 0);
    checkVal("mid_rst_busy", bus.busy, 0);
    checkVal("mid_rst_out_valid", bus.out_valid, 0);
    checkVal("mid_rst_out_data", bus.out_data, 0);
    checkVal("mid_rst_out_last", bus.out_last, 0);
    clearModel();
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(4, 0, 1'b1, 0, 1'b0);
    checkOutput("post_rst", 1'b0, waitCycles);

    $display("[TB] k_len 0 after a nonzero run");
    applyStimulus(0, 0, 1'b0, 0, 1'b0);
    checkVal("k0_in_ready", bus.in_ready, 0);
    checkVal("k0_busy", bus.busy, 1);
    checkOutput("k0", 1'b0, waitCycles);
    checkVal("k0_latency", waitCycles, 1);

    $display("[TB] accumulator wrap, k_len 65535");
    applyStimulus(65535, -256, 1'b0, 2, 1'b0);
    checkOutput("wrap", 1'b0, waitCycles);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
